// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage load/store initiator with alignment check, variable-latency handshake and load extension
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid, req_read, req_write    request from EX/MEM and its direction
//   req_addr, req_wdata               byte address, right-justified store data
//   req_size, req_signed              0 byte / 1 half / 2 word / 3 illegal; sign-extend loads
//   mem_addr, mem_wdata, mem_be       word address, lane-replicated store data, byte enables
//   mem_read, mem_write               memory strobes, held until mem_ready or timeout
//   mem_ready, mem_rdata              memory completion and read word
//   stall                             combinational hold for upstream latches
//   rsp_valid, rsp_data, rsp_err      one-cycle response toward MEM/WB
module mem_req_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [1:0] off_q, size_q;
    logic sgn_q, bad, timeout;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;
    assign bad = ~(req_read ^ req_write) | (req_size == 2'd3)
               | (req_size == 2'd1 & req_addr[0]) | (req_size == 2'd2 & |req_addr[1:0]);
    // The cycle that would bring the count up to TIMEOUT is the last strobe cycle.
    assign timeout = cnt == CW'(TIMEOUT - 1);
    assign stall = (state == ISSUE) | (state == IDLE & req_valid & (req_read | req_write));
    assign lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    assign lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ext = size_q == 2'd0 ? {{24{sgn_q & lane_b[7]}}, lane_b} :
                 size_q == 2'd1 ? {{16{sgn_q & lane_h[15]}}, lane_h} : mem_rdata;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !req_valid ? IDLE : bad ? ERR : ISSUE;
            ISSUE:   state_n = mem_ready ? RESP : timeout ? ERR : ISSUE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= (state == ISSUE && !mem_ready) ? cnt + 1'b1 : '0;
            rsp_valid <= state_n == RESP || state_n == ERR;
            rsp_err   <= state_n == ERR;
            // mem_read is still high in the completing ISSUE cycle, so it marks a load.
            rsp_data  <= (state_n == RESP && mem_read) ? ext : '0;
            if (state == IDLE && state_n == ISSUE) begin
                off_q     <= req_addr[1:0];
                size_q    <= req_size;
                sgn_q     <= req_signed;
                mem_addr  <= {2'b00, req_addr[31:2]};
                mem_be    <= req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
                             req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'hF;
                mem_wdata <= req_size == 2'd0 ? {4{req_wdata[7:0]}} :
                             req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
                mem_read  <= req_read;
                mem_write <= req_write;
            end else if (state_n != ISSUE) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed bench for mem_req_ctrl with a lane-level reference model
module tb_mem_req_ctrl;
    localparam int TO = 15;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic [1:0] req_size = '0;
    logic mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, rsp_data;
    logic [3:0] mem_be;
    logic mem_read, mem_write, stall, rsp_valid, rsp_err;

    mem_req_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_signed(req_signed), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_read(mem_read),
        .mem_write(mem_write), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic en = 1'b0;
    logic e_rd = 0, e_wr = 0, e_rv = 0, e_err = 0, e_stall = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_data = 0;
    logic [3:0] e_be = 0;
    int strobe_cycles = 0, stall_cycles = 0, rsp_pulses = 0;
    logic [31:0] last_rsp = 0, last_addr = 0, last_wdata = 0;
    logic [3:0] last_be = 0;
    logic last_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        int n = 1 << sz;
        int off = int'(a[1:0]);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
        int n = 1 << sz;
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sgn);
        int bits = 8 << sz;
        logic [63:0] mask = (64'd1 << bits) - 64'd1;
        logic [63:0] v = (64'(rd) >> (8 * int'(a[1:0]))) & mask;
        if (sgn && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    always @(negedge clk) if (en) begin
        check("mem_read", 32'(mem_read), 32'(e_rd));
        check("mem_write", 32'(mem_write), 32'(e_wr));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("stall", 32'(stall), 32'(e_stall));
        if (e_rd || e_wr) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_be", 32'(mem_be), 32'(e_be));
            if (e_wr) check("mem_wdata", mem_wdata, e_wdata);
        end
        if (e_rv) check("rsp_data", rsp_data, e_data);
        if (mem_read || mem_write) begin
            strobe_cycles++;
            last_addr = mem_addr;
            last_be = mem_be;
            last_wdata = mem_wdata;
        end
        if (stall) stall_cycles++;
        if (rsp_valid) begin
            rsp_pulses++;
            last_rsp = rsp_data;
            last_err = rsp_err;
        end
    end

    task automatic set_exp(input logic rd, input logic wr, input logic rv, input logic err,
                           input logic stl, input logic [31:0] data);
        e_rd = rd; e_wr = wr; e_rv = rv; e_err = err; e_stall = stl; e_data = data;
    endtask

    // k = cycles of strobe until mem_ready (k >= 1); k = 0 means memory never answers.
    task automatic run(input logic v, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic sgn,
                       input int k, input logic [31:0] rdat);
        int n = 1 << sz;
        bit ok = v && (rd ^ wr) && sz != 2'd3 && ((int'(a[1:0]) & (n - 1)) == 0);
        int lim = (k == 0) ? TO : k;
        bit err = !ok || k == 0;
        strobe_cycles = 0; stall_cycles = 0; rsp_pulses = 0;
        req_valid = v; req_read = rd; req_write = wr; req_addr = a;
        req_wdata = wd; req_size = sz; req_signed = sgn;
        mem_ready = 1'b0; mem_rdata = $urandom;
        set_exp(0, 0, 0, 0, v & (rd | wr), 0);
        @(posedge clk) #1;
        if (ok) begin
            e_addr = a / 4; e_be = m_be(a, sz); e_wdata = m_wdata(wd, sz);
            for (int c = 1; c <= lim; c++) begin
                req_valid = 1'(($urandom)); req_read = 1'(($urandom)); req_write = 1'(($urandom));
                req_addr = $urandom; req_size = 2'(($urandom)); req_wdata = $urandom;
                mem_ready = (c == k);
                mem_rdata = (c == k) ? rdat : $urandom;
                set_exp(rd, wr, 0, 0, 1, 0);
                @(posedge clk) #1;
            end
        end
        req_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = $urandom;
        set_exp(0, 0, 1, err, 0, (err || wr) ? 32'h0 : m_load(rdat, a, sz, sgn));
        @(posedge clk) #1;
        mem_ready = 1'b0;
    endtask

    task automatic idle_cycle(input logic stray);
        req_valid = 1'b0; mem_ready = stray; mem_rdata = $urandom;
        set_exp(0, 0, 0, 0, 0, 0);
        @(posedge clk) #1;
        mem_ready = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_be"}, 32'(mem_be), 0);
        check({tag, "_strobes"}, 32'({mem_read, mem_write}), 0);
        check({tag, "_rsp"}, 32'({rsp_valid, rsp_err}), 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_stall"}, 32'(stall), 0);
    endtask

    initial begin
        #2 all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        en = 1'b1;
        idle_cycle(1'b1);
        // word load, memory answers on the second strobe cycle
        run(1, 1, 0, 32'h10, 0, 2'd2, 0, 2, 32'hDEADBEEF);
        check("wl_rsp", last_rsp, 32'hDEADBEEF);
        check("wl_addr", last_addr, 32'h4);
        check("wl_be", 32'(last_be), 32'hF);
        check("wl_stall_cycles", 32'(stall_cycles), 3);
        check("wl_pulses", 32'(rsp_pulses), 1);
        // byte loads, back-to-back
        run(1, 1, 0, 32'h13, 0, 2'd0, 1, 1, 32'h80112233);
        check("lb_rsp", last_rsp, 32'hFFFFFF80);
        check("lb_be", 32'(last_be), 32'b1000);
        run(1, 1, 0, 32'h13, 0, 2'd0, 0, 3, 32'h80112233);
        check("lbu_rsp", last_rsp, 32'h00000080);
        // half store
        run(1, 0, 1, 32'h06, 32'h0000ABCD, 2'd1, 0, 3, 0);
        check("sh_wdata", last_wdata, 32'hABCDABCD);
        check("sh_be", 32'(last_be), 32'b1100);
        check("sh_strobes", 32'(strobe_cycles), 3);
        check("sh_rsp", last_rsp, 0);
        // half loads and a byte store
        run(1, 1, 0, 32'h22, 0, 2'd1, 1, 2, 32'h80017FFF);
        check("lh_rsp", last_rsp, 32'hFFFF8001);
        run(1, 1, 0, 32'h20, 0, 2'd1, 0, 1, 32'h80017FFF);
        check("lhu_rsp", last_rsp, 32'h00007FFF);
        run(1, 0, 1, 32'h41, 32'h1234565A, 2'd0, 0, 1, 0);
        check("sb_wdata", last_wdata, 32'h5A5A5A5A);
        check("sb_be", 32'(last_be), 32'b0010);
        // rejected requests
        run(1, 0, 1, 32'h02, 32'h55, 2'd2, 0, 1, 0);
        check("mis_strobes", 32'(strobe_cycles), 0);
        check("mis_err", 32'(last_err), 1);
        check("mis_stall_cycles", 32'(stall_cycles), 1);
        run(1, 1, 1, 32'h08, 0, 2'd2, 0, 1, 0);
        check("both_strobes", 32'(strobe_cycles), 0);
        check("both_err", 32'(last_err), 1);
        run(1, 0, 0, 32'h08, 0, 2'd2, 0, 1, 0);
        check("none_stall_cycles", 32'(stall_cycles), 0);
        run(1, 1, 0, 32'h08, 0, 2'd3, 0, 1, 0);
        check("size3_err", 32'(last_err), 1);
        run(1, 1, 0, 32'h05, 0, 2'd1, 0, 1, 0);
        check("mis_half_strobes", 32'(strobe_cycles), 0);
        // timeout
        run(1, 1, 0, 32'h30, 0, 2'd2, 0, 0, 0);
        check("to_strobes", 32'(strobe_cycles), TO);
        check("to_err", 32'(last_err), 1);
        check("to_pulses", 32'(rsp_pulses), 1);
        // ready on the last allowed cycle wins over the timeout
        run(1, 1, 0, 32'h34, 0, 2'd2, 0, TO, 32'h0BADF00D);
        check("edge_rsp", last_rsp, 32'h0BADF00D);
        check("edge_err", 32'(last_err), 0);
        idle_cycle(1'b1);
        // reset during ISSUE
        req_valid = 1; req_read = 1; req_write = 0; req_addr = 32'h20; req_size = 2'd2;
        set_exp(0, 0, 0, 0, 1, 0);
        @(posedge clk) #1;
        req_valid = 0;
        e_addr = 32'h8; e_be = 4'hF;
        set_exp(1, 0, 0, 0, 1, 0);
        @(posedge clk) #1;
        en = 1'b0;
        #1 rst_n = 1'b0;
        #1 all_zero("midrst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        en = 1'b1;
        rsp_pulses = 0;
        mem_rdata = 32'hCAFEF00D;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("midrst_pulses", 32'(rsp_pulses), 0);
        en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
